// File: rtl/wishbone_vga_fill.sv
// wishbone_vga_fill: Wishbone master that fills VGA memory with a constant or stepped data pattern.
// Ports: clk_i/rst_i clock and sync active-high reset; cmd_* fill command (valid/ready handshake,
// start address, word count, first data, per-word data step, byte select); abort_i stops a fill;
// wb_* Wishbone write master; busy_o fill in progress; done_o completion pulse; aborted_o qualifies done_o.
module wishbone_vga_fill #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [31:0]       cmd_data_i,
    input  logic [31:0]       cmd_step_i,
    input  logic [3:0]        cmd_sel_i,
    input  logic              abort_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o
);
    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat, stp;
    logic [3:0]        sel;
    logic [LEN_W-1:0]  rem;
    logic              abt;
    logic              accept, ack, last;
    assign accept = cmd_valid_i && state == IDLE;
    // acks outside WRITE are ignored
    assign ack  = wb_ack_i && state == WRITE;
    assign last = ack && rem == LEN_W'(1);
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (cmd_len_i == '0 ? FINISH : WRITE) : IDLE;
            WRITE:   state_nxt = (abort_i || last) ? FINISH : WRITE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            adr   <= '0;
            dat   <= '0;
            stp   <= '0;
            sel   <= '0;
            rem   <= '0;
            abt   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                adr <= cmd_addr_i;
                dat <= cmd_data_i;
                stp <= cmd_step_i;
                sel <= cmd_sel_i;
                rem <= cmd_len_i;
                abt <= 1'b0;
            end else if (ack) begin
                adr <= adr + ADDR_W'(1);
                dat <= dat + stp;
                rem <= rem - LEN_W'(1);
            end
            if (state == WRITE && abort_i) abt <= 1'b1;
        end
    end
    assign cmd_ready_o = state == IDLE;
    assign wb_cyc_o    = state == WRITE;
    assign wb_stb_o    = state == WRITE;
    assign wb_we_o     = state == WRITE;
    assign wb_adr_o    = adr;
    assign wb_dat_o    = dat;
    assign wb_sel_o    = sel;
    assign busy_o      = state != IDLE;
    assign done_o      = state == FINISH;
    assign aborted_o   = state == FINISH && abt;
endmodule

// File: tb/tb_wishbone_vga_fill.sv
// tb_wishbone_vga_fill: directed self-checking bench for wishbone_vga_fill.
// Inputs are driven and outputs sampled on the falling edge of clk_i.
module tb_wishbone_vga_fill;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [11:0] cmd_addr_i = '0;
    logic [12:0] cmd_len_i = '0;
    logic [31:0] cmd_data_i = '0;
    logic [31:0] cmd_step_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        abort_i = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [11:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i = 1'b0;
    logic        busy_o, done_o, aborted_o;
    int          vectors = 0;
    int          miscompares = 0;

    wishbone_vga_fill #(.ADDR_W(12), .LEN_W(13)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
        .cmd_step_i(cmd_step_i), .cmd_sel_i(cmd_sel_i), .abort_i(abort_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_ack_i(wb_ack_i), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    // presents a command for one cycle; returns on the falling edge after the accepting edge
    task automatic send(input logic [11:0] a, input logic [12:0] l, input logic [31:0] d,
                        input logic [31:0] s, input logic [3:0] b);
        cmd_addr_i  = a;
        cmd_len_i   = l;
        cmd_data_i  = d;
        cmd_step_i  = s;
        cmd_sel_i   = b;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    initial begin
        logic [11:0] g_adr [3];
        logic [31:0] g_dat [3];
        g_adr = '{12'hFFE, 12'hFFF, 12'h000};
        g_dat = '{32'd5, 32'd8, 32'd11};
        tick();
        // reset with a command pending: it must not be accepted
        rst_i = 1'b1;
        cmd_valid_i = 1'b1;
        cmd_len_i = 13'd2;
        tick();
        tick();
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        rst_i = 1'b0;
        cmd_valid_i = 1'b0;
        tick();
        chk("rst_no_accept_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);

        // ack and abort while idle are ignored
        wb_ack_i = 1'b1;
        abort_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        abort_i = 1'b0;
        chk("idle_ack_busy", 32'(busy_o), 32'd0);
        chk("idle_ack_done", 32'(done_o), 32'd0);

        // solid fill, slave acks every other cycle
        send(12'h010, 13'd4, 32'h0000_0FFF, 32'd0, 4'hF);
        chk("solid_stb_latency", 32'(wb_stb_o), 32'd1);
        chk("solid_ready_low", 32'(cmd_ready_o), 32'd0);
        for (int w = 0; w < 4; w++) begin
            chk("solid_adr", 32'(wb_adr_o), 32'h010 + 32'(w));
            chk("solid_dat", wb_dat_o, 32'h0000_0FFF);
            chk("solid_we", 32'(wb_we_o), 32'd1);
            tick();
            chk("solid_stb_hold", 32'(wb_stb_o), 32'd1);
            chk("solid_adr_hold", 32'(wb_adr_o), 32'h010 + 32'(w));
            wb_ack_i = 1'b1;
            tick();
            wb_ack_i = 1'b0;
        end
        chk("solid_done", 32'(done_o), 32'd1);
        chk("solid_aborted", 32'(aborted_o), 32'd0);
        chk("solid_stb_off", 32'(wb_cyc_o), 32'd0);
        chk("solid_finish_busy", 32'(busy_o), 32'd1);
        tick();
        chk("solid_done_once", 32'(done_o), 32'd0);
        chk("solid_ready_back", 32'(cmd_ready_o), 32'd1);

        // gradient with address wrap, zero-wait slave
        send(12'hFFE, 13'd3, 32'd5, 32'd3, 4'hF);
        for (int w = 0; w < 3; w++) begin
            chk("grad_stb", 32'(wb_stb_o), 32'd1);
            chk("grad_adr", 32'(wb_adr_o), 32'(g_adr[w]));
            chk("grad_dat", wb_dat_o, g_dat[w]);
            wb_ack_i = 1'b1;
            tick();
        end
        wb_ack_i = 1'b0;
        chk("grad_done", 32'(done_o), 32'd1);
        chk("grad_stb_off", 32'(wb_stb_o), 32'd0);
        tick();

        // zero-length fill goes straight to the completion pulse
        send(12'h123, 13'd0, 32'h1, 32'h1, 4'hF);
        chk("len0_cyc", 32'(wb_cyc_o), 32'd0);
        chk("len0_done", 32'(done_o), 32'd1);
        chk("len0_ready_low", 32'(cmd_ready_o), 32'd0);
        tick();
        chk("len0_done_off", 32'(done_o), 32'd0);
        chk("len0_ready", 32'(cmd_ready_o), 32'd1);
        chk("len0_cyc_after", 32'(wb_cyc_o), 32'd0);

        // abort on the cycle of the 2nd ack of an 8-word fill
        send(12'h200, 13'd8, 32'h100, 32'd1, 4'h3);
        wb_ack_i = 1'b1;
        tick();
        chk("abort_adr2", 32'(wb_adr_o), 32'h201);
        abort_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_stb_off", 32'(wb_stb_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd1);
        chk("abort_flag", 32'(aborted_o), 32'd1);
        chk("abort_count_adr", 32'(wb_adr_o), 32'h202);
        chk("abort_count_dat", wb_dat_o, 32'h102);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_flag_clear", 32'(aborted_o), 32'd0);
        chk("abort_ready", 32'(cmd_ready_o), 32'd1);

        // slave stalls 5 cycles before acking
        send(12'h055, 13'd1, 32'hDEAD_BEEF, 32'd7, 4'h5);
        for (int c = 0; c < 5; c++) begin
            chk("stall_stb", 32'(wb_stb_o), 32'd1);
            chk("stall_adr", 32'(wb_adr_o), 32'h055);
            chk("stall_dat", wb_dat_o, 32'hDEAD_BEEF);
            chk("stall_sel", 32'(wb_sel_o), 32'h5);
            tick();
        end
        chk("stall_not_done", 32'(done_o), 32'd0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("stall_done", 32'(done_o), 32'd1);
        chk("stall_aborted", 32'(aborted_o), 32'd0);
        tick();

        // reset during the 3rd write of a 6-word fill
        send(12'h300, 13'd6, 32'd0, 32'd1, 4'hF);
        wb_ack_i = 1'b1;
        tick();
        tick();
        wb_ack_i = 1'b0;
        chk("rstmid_adr3", 32'(wb_adr_o), 32'h302);
        chk("rstmid_stb_on", 32'(wb_stb_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rstmid_stb_off", 32'(wb_stb_o), 32'd0);
        chk("rstmid_cyc_off", 32'(wb_cyc_o), 32'd0);
        chk("rstmid_no_done", 32'(done_o), 32'd0);
        chk("rstmid_adr_clr", 32'(wb_adr_o), 32'd0);
        tick();
        chk("rstmid_no_done_later", 32'(done_o), 32'd0);
        send(12'h010, 13'd1, 32'd7, 32'd0, 4'hF);
        chk("rstmid_new_stb", 32'(wb_stb_o), 32'd1);
        chk("rstmid_new_adr", 32'(wb_adr_o), 32'h010);
        chk("rstmid_new_dat", wb_dat_o, 32'd7);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        chk("rstmid_new_done", 32'(done_o), 32'd1);
        tick();
        chk("rstmid_new_ready", 32'(cmd_ready_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
